alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue stage between decode and the ALU, with tagged write-back and flush handling
module alu_issue #(
  parameter int RW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_dcd_valid,
  input  logic [3:0]    i_dcd_op,
  input  logic [31:0]   i_dcd_a,
  input  logic [31:0]   i_dcd_b,
  input  logic [RW-1:0] i_dcd_wreg,
  input  logic          i_dcd_wr,
  input  logic          i_dcd_wf,
  input  logic          i_dcd_cond_ok,
  output logic          o_dcd_stall,
  output logic          o_alu_ce,
  output logic          o_alu_valid,
  output logic [3:0]    o_alu_op,
  output logic [31:0]   o_alu_a,
  output logic [31:0]   o_alu_b,
  input  logic [31:0]   i_alu_c,
  input  logic [3:0]    i_alu_f,
  input  logic          i_alu_valid,
  input  logic          i_alu_busy,
  input  logic          i_alu_illegal,
  output logic          o_wb_we,
  output logic [RW-1:0] o_wb_reg,
  output logic [31:0]   o_wb_data,
  output logic          o_flags_we,
  output logic [3:0]    o_flags,
  output logic          o_illegal,
  output logic          o_idle,
  output logic [15:0]   o_retire_cnt
);

  typedef enum logic [1:0] {IDLE, PEND, MPYW, DRAIN} state_t;

  state_t        state_q;
  logic [RW-1:0] tag_wreg_q;
  logic          tag_wr_q;
  logic          tag_wf_q;

  logic issue;
  logic is_mpy;
  logic active;
  logic retire;
  logic trap;
  logic unused_busy;

  // Multiply completion is signalled only by valid/illegal; busy carries no extra information here.
  assign unused_busy = i_alu_busy;

  assign o_dcd_stall = (state_q == MPYW) || (state_q == DRAIN);
  assign issue       = i_dcd_valid && i_dcd_cond_ok && !o_dcd_stall && !i_clear;
  assign is_mpy      = (i_dcd_op[3:1] == 3'b101);
  assign o_alu_ce    = issue;
  assign o_alu_valid = issue;
  assign o_alu_op    = i_dcd_op;
  assign o_alu_a     = i_dcd_a;
  assign o_alu_b     = i_dcd_b;
  assign o_idle      = (state_q == IDLE);

  assign active = (state_q == PEND) || (state_q == MPYW);
  assign trap   = active && i_alu_illegal && !i_clear;
  assign retire = active && i_alu_valid && !i_alu_illegal && !i_clear;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      tag_wreg_q   <= '0;
      tag_wr_q     <= 1'b0;
      tag_wf_q     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_reg     <= '0;
      o_wb_data    <= '0;
      o_flags_we   <= 1'b0;
      o_flags      <= '0;
      o_illegal    <= 1'b0;
      o_retire_cnt <= '0;
    end else begin
      o_wb_we    <= retire && tag_wr_q;
      o_flags_we <= retire && tag_wf_q;
      o_illegal  <= trap;
      if (retire) begin
        o_wb_reg     <= tag_wreg_q;
        o_wb_data    <= i_alu_c;
        o_flags      <= i_alu_f;
        o_retire_cnt <= o_retire_cnt + 16'd1;
      end
      if (issue) begin
        tag_wreg_q <= i_dcd_wreg;
        tag_wr_q   <= i_dcd_wr;
        tag_wf_q   <= i_dcd_wf;
      end
      case (state_q)
        // A new issue in the retire cycle keeps the pipe at one op per cycle.
        IDLE, PEND: state_q <= issue ? (is_mpy ? MPYW : PEND) : IDLE;
        MPYW: begin
          if (i_clear)
            state_q <= DRAIN;
          else if (i_alu_valid || i_alu_illegal)
            state_q <= IDLE;
        end
        DRAIN: begin
          if (!i_clear && (i_alu_valid || i_alu_illegal))
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
